// File: rtl/fc_cu_multipass.sv
// Multi-pass control unit for a fully-connected layer: sequences input/weight reads,
// MAC clear/enable and per-group writes. Optional ReLU gating behind `FC_CU_RELU_EN`.
module fc_cu_multipass #(
  parameter int IFM_DEPTH   = 120,
  parameter int NUM_NEURONS = 84,
  parameter int LANES       = 16,
  parameter int READ_LAT    = 2,
  parameter int IFM_AW      = $clog2(IFM_DEPTH),
  parameter int WM_AW       = $clog2(((NUM_NEURONS + LANES - 1) / LANES) * IFM_DEPTH),
  parameter int PASS_W      = (((NUM_NEURONS + LANES - 1) / LANES) > 1)
                              ? $clog2((NUM_NEURONS + LANES - 1) / LANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_from_previous,
  output logic              end_to_previous,
  output logic              start_to_next,
  input  logic              end_from_next,
  output logic              ifm_rd_en,
  output logic [IFM_AW-1:0] ifm_addr,
  output logic              wm_rd_en,
  output logic [WM_AW-1:0]  wm_addr,
  output logic              acc_clear,
  output logic              mac_en,
  output logic              wr_en_next,
  output logic [PASS_W-1:0] wr_group,
  output logic [LANES-1:0]  lane_mask,
  output logic              busy,
`ifdef FC_CU_RELU_EN
  input  logic              relu_bypass,
  output logic              relu_en,
`endif
  output logic [2:0]        dbg_state_o
);

  localparam int NUM_PASSES = (NUM_NEURONS + LANES - 1) / LANES;
  localparam int LAST_LANES = NUM_NEURONS - (NUM_PASSES - 1) * LANES;
  localparam int DRN_W      = $clog2(READ_LAT + 1);

  localparam logic [LANES-1:0]  FULL_MASK = '1;
  localparam logic [LANES-1:0]  LAST_MASK = FULL_MASK >> (LANES - LAST_LANES);
  localparam logic [IFM_AW-1:0] IFM_LAST  = IFM_AW'(IFM_DEPTH - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(READ_LAT);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IFM_AW-1:0]   ifm_addr_q, ifm_addr_d;
  logic [WM_AW-1:0]    wm_addr_q, wm_addr_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [READ_LAT-1:0] rd_dly_q;
  logic [READ_LAT-1:0] clr_dly_q;
  logic                last_drain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ifm_addr_q <= '0;
      wm_addr_q  <= '0;
      pass_q     <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      ifm_addr_q <= ifm_addr_d;
      wm_addr_q  <= wm_addr_d;
      pass_q     <= pass_d;
      drain_q    <= drain_d;
    end
  end

  // wm_addr is a single running counter across passes, so it always equals
  // pass*IFM_DEPTH + ifm_addr while reading without a multiplier.
  always_comb begin
    state_d    = state_q;
    ifm_addr_d = ifm_addr_q;
    wm_addr_d  = wm_addr_q;
    pass_d     = pass_q;
    drain_d    = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_from_previous) begin
          state_d    = S_RUN;
          ifm_addr_d = '0;
          wm_addr_d  = '0;
          pass_d     = '0;
        end
      end
      S_RUN: begin
        wm_addr_d = wm_addr_q + WM_AW'(1);
        if (ifm_addr_q == IFM_LAST) begin
          ifm_addr_d = '0;
          drain_d    = '0;
          state_d    = S_DRAIN;
        end else begin
          ifm_addr_d = ifm_addr_q + IFM_AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRN_LAST) begin
          drain_d = '0;
          if (pass_q == PASS_LAST) begin
            state_d = S_DONE;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = S_RUN;
          end
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      S_DONE:  state_d = S_HOLD;
      S_HOLD:  if (end_from_next) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay lines align read-side strobes with data arriving at the MAC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_dly_q  <= '0;
      clr_dly_q <= '0;
    end else begin
      rd_dly_q  <= (rd_dly_q << 1) | READ_LAT'(ifm_rd_en);
      clr_dly_q <= (clr_dly_q << 1) | READ_LAT'(ifm_rd_en & (ifm_addr_q == '0));
    end
  end

  assign last_drain      = (state_q == S_DRAIN) && (drain_q == DRN_LAST);
  assign end_to_previous = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign start_to_next   = (state_q == S_DONE);
  assign ifm_rd_en       = (state_q == S_RUN);
  assign wm_rd_en        = (state_q == S_RUN);
  assign ifm_addr        = ifm_addr_q;
  assign wm_addr         = wm_addr_q;
  assign wr_en_next      = last_drain;
  assign wr_group        = last_drain ? pass_q : '0;
  assign lane_mask       = !last_drain ? '0 : ((pass_q == PASS_LAST) ? LAST_MASK : FULL_MASK);
  assign mac_en          = rd_dly_q[READ_LAT-1];
  assign acc_clear       = clr_dly_q[READ_LAT-1];
  assign dbg_state_o     = state_q;

`ifdef FC_CU_RELU_EN
  assign relu_en = last_drain & ~relu_bypass;
`endif

endmodule

// File: tb/tb_fc_cu_multipass.sv
// Bench for fc_cu_multipass: a default-parameter instance and a single-pass READ_LAT=3
// instance, both checked every cycle against an arithmetic timeline model.
module tb_fc_cu_multipass;

  localparam int A_D  = 120;
  localparam int A_NN = 84;
  localparam int A_LN = 16;
  localparam int A_L  = 2;
  localparam int A_NP = (A_NN + A_LN - 1) / A_LN;
  localparam int A_P  = A_D + A_L + 1;
  localparam int A_WAW = $clog2(A_NP * A_D);
  localparam int A_PW  = (A_NP > 1) ? $clog2(A_NP) : 1;

  localparam int B_D  = 120;
  localparam int B_NN = 10;
  localparam int B_LN = 16;
  localparam int B_L  = 3;
  localparam int B_NP = (B_NN + B_LN - 1) / B_LN;
  localparam int B_P  = B_D + B_L + 1;
  localparam int B_WAW = $clog2(B_NP * B_D);
  localparam int B_PW  = (B_NP > 1) ? $clog2(B_NP) : 1;

  typedef struct {
    int etp; int stn; int rd; int clr; int mac; int wr; int busy;
    int ifm_addr; int wm_addr; int grp; int mask;
  } exp_t;

  logic clk, reset;
  logic start_a, end_a, start_b, end_b;

  logic a_etp, a_stn, a_rd, a_wrd, a_clr, a_mac, a_wr, a_busy;
  logic [$clog2(A_D)-1:0] a_ifa;
  logic [A_WAW-1:0] a_wma;
  logic [A_PW-1:0]  a_grp;
  logic [A_LN-1:0]  a_mask;
  logic [2:0]       a_dbg;

  logic b_etp, b_stn, b_rd, b_wrd, b_clr, b_mac, b_wr, b_busy;
  logic [$clog2(B_D)-1:0] b_ifa;
  logic [B_WAW-1:0] b_wma;
  logic [B_PW-1:0]  b_grp;
  logic [B_LN-1:0]  b_mask;
  logic [2:0]       b_dbg;

`ifdef FC_CU_RELU_EN
  logic relu_bypass, a_relu, b_relu;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int a_mode = 0, a_o = 0, b_mode = 0, b_o = 0;
  bit go_a = 0, go_b = 0;
  int hold_a = 0, hold_b = 0;
  int run_cyc_a = 0, stn_cyc_a = -1, wr_cnt_a = 0, wm_max_a = 0;
  int run_cyc_b = 0, stn_cyc_b = -1, wr_cnt_b = 0;
  int addr0_b = 0, addr119_b = 0;
  bit b_mac_prev = 0;
  int post_rst_wr = 0;

  fc_cu_multipass #(.IFM_DEPTH(A_D), .NUM_NEURONS(A_NN), .LANES(A_LN), .READ_LAT(A_L)) dut_a (
    .clk(clk), .reset(reset), .start_from_previous(start_a), .end_to_previous(a_etp),
    .start_to_next(a_stn), .end_from_next(end_a), .ifm_rd_en(a_rd), .ifm_addr(a_ifa),
    .wm_rd_en(a_wrd), .wm_addr(a_wma), .acc_clear(a_clr), .mac_en(a_mac),
    .wr_en_next(a_wr), .wr_group(a_grp), .lane_mask(a_mask), .busy(a_busy),
`ifdef FC_CU_RELU_EN
    .relu_bypass(relu_bypass), .relu_en(a_relu),
`endif
    .dbg_state_o(a_dbg)
  );

  fc_cu_multipass #(.IFM_DEPTH(B_D), .NUM_NEURONS(B_NN), .LANES(B_LN), .READ_LAT(B_L)) dut_b (
    .clk(clk), .reset(reset), .start_from_previous(start_b), .end_to_previous(b_etp),
    .start_to_next(b_stn), .end_from_next(end_b), .ifm_rd_en(b_rd), .ifm_addr(b_ifa),
    .wm_rd_en(b_wrd), .wm_addr(b_wma), .acc_clear(b_clr), .mac_en(b_mac),
    .wr_en_next(b_wr), .wr_group(b_grp), .lane_mask(b_mask), .busy(b_busy),
`ifdef FC_CU_RELU_EN
    .relu_bypass(relu_bypass), .relu_en(b_relu),
`endif
    .dbg_state_o(b_dbg)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the offset o since the first RUN cycle: each pass is
  // d read cycles followed by l+1 drain cycles; DONE sits at offset np*p.
  function automatic exp_t model(input int mode, input int o, input int d, input int l,
                                 input int np, input int nn, input int ln);
    exp_t e;
    int p, pass, j, q;
    p = d + l + 1;
    e.etp = (mode == 0) ? 1 : 0; e.busy = (mode != 0) ? 1 : 0;
    e.stn = 0; e.rd = 0; e.clr = 0; e.mac = 0; e.wr = 0;
    e.ifm_addr = 0; e.wm_addr = 0; e.grp = 0; e.mask = 0;
    if (mode == 1 && o < np * p) begin
      pass = o / p;
      j = o % p;
      if (j < d) begin e.rd = 1; e.ifm_addr = j; e.wm_addr = pass * d + j; end
      if (j == p - 1) begin
        e.wr = 1; e.grp = pass;
        e.mask = (pass == np - 1) ? ((1 << (nn - (np - 1) * ln)) - 1) : ((1 << ln) - 1);
      end
    end
    if (mode == 1 && o == np * p) e.stn = 1;
    q = o - l;
    if (mode != 0 && q >= 0 && q < np * p && (q % p) < d) begin
      e.mac = 1;
      e.clr = ((q % p) == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e, input logic etp, input logic stn,
                           input logic rd, input logic wrd, input logic clr, input logic mac,
                           input logic wr, input logic busy, input logic [31:0] ifa,
                           input logic [31:0] wma, input logic [31:0] grp, input logic [31:0] mask);
    chk({tag, ".end_to_previous"}, 32'(etp), e.etp);
    chk({tag, ".start_to_next"}, 32'(stn), e.stn);
    chk({tag, ".ifm_rd_en"}, 32'(rd), e.rd);
    chk({tag, ".wm_rd_en"}, 32'(wrd), e.rd);
    chk({tag, ".acc_clear"}, 32'(clr), e.clr);
    chk({tag, ".mac_en"}, 32'(mac), e.mac);
    chk({tag, ".wr_en_next"}, 32'(wr), e.wr);
    chk({tag, ".busy"}, 32'(busy), e.busy);
    chk({tag, ".ifm_addr"}, ifa, e.ifm_addr);
    if (e.rd != 0) chk({tag, ".wm_addr"}, wma, e.wm_addr);
    if (e.wr != 0) begin
      chk({tag, ".wr_group"}, grp, e.grp);
      chk({tag, ".lane_mask"}, mask, e.mask);
    end
  endtask

  task automatic check_both();
    exp_t ea, eb;
    ea = model(a_mode, a_o, A_D, A_L, A_NP, A_NN, A_LN);
    eb = model(b_mode, b_o, B_D, B_L, B_NP, B_NN, B_LN);
    check_all("a", ea, a_etp, a_stn, a_rd, a_wrd, a_clr, a_mac, a_wr, a_busy,
              32'(a_ifa), 32'(a_wma), 32'(a_grp), 32'(a_mask));
    check_all("b", eb, b_etp, b_stn, b_rd, b_wrd, b_clr, b_mac, b_wr, b_busy,
              32'(b_ifa), 32'(b_wma), 32'(b_grp), 32'(b_mask));
`ifdef FC_CU_RELU_EN
    chk("a.relu_en", 32'(a_relu), (ea.wr != 0 && !relu_bypass) ? 1 : 0);
    chk("b.relu_en", 32'(b_relu), (eb.wr != 0 && !relu_bypass) ? 1 : 0);
`endif
  endtask

  task automatic advance(inout int mode, inout int o, input logic st, input logic en, input int last);
    if (!reset) mode = 0;
    else case (mode)
      0: if (st) begin mode = 1; o = 0; end
      1: begin o++; if (o > last) mode = 2; end
      default: begin o++; if (en) mode = 0; end
    endcase
  endtask

  task automatic drive(input int mode, inout bit go, inout int hold, output logic st, output logic en);
    st = 0; en = 0;
    case (mode)
      0: if (go) begin st = 1; go = 0; end
      1: begin st = ($urandom_range(0, 15) == 0); en = ($urandom_range(0, 15) == 0); end
      default: begin
        st = ($urandom_range(0, 3) == 0);
        if (hold == 0) en = 1; else hold--;
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_both();
    if (a_wr === 1'b1) begin
      chk("a.group_seq", 32'(a_grp), wr_cnt_a);
      chk("a.mask_by_group", 32'(a_mask), (wr_cnt_a < 5) ? 32'h0000FFFF : 32'h0000000F);
      wr_cnt_a++;
      post_rst_wr++;
    end
    if (a_stn === 1'b1) stn_cyc_a = cyc;
    if (a_rd === 1'b1 && int'(a_wma) > wm_max_a) wm_max_a = int'(a_wma);
    if (b_rd === 1'b1 && b_ifa == 0) addr0_b = cyc;
    if (b_rd === 1'b1 && b_ifa == 119) addr119_b = cyc;
    if (b_clr === 1'b1) chk("b.clear_lag", cyc - addr0_b, B_L);
    if (b_mac === 1'b1 && !b_mac_prev) chk("b.first_mac_lag", cyc - addr0_b, B_L);
    b_mac_prev = (b_mac === 1'b1);
    if (b_wr === 1'b1) begin chk("b.write_lag", cyc - addr119_b, B_L + 1); wr_cnt_b++; post_rst_wr++; end
    if (b_stn === 1'b1) stn_cyc_b = cyc;
    if (a_mode == 0 && go_a) begin run_cyc_a = cyc + 1; wr_cnt_a = 0; wm_max_a = 0; hold_a = $urandom_range(0, 10); end
    if (b_mode == 0 && go_b) begin run_cyc_b = cyc + 1; wr_cnt_b = 0; hold_b = $urandom_range(0, 10); end
    drive(a_mode, go_a, hold_a, start_a, end_a);
    drive(b_mode, go_b, hold_b, start_b, end_b);
`ifdef FC_CU_RELU_EN
    relu_bypass = ($urandom_range(0, 1) == 1);
`endif
    advance(a_mode, a_o, start_a, end_a, A_NP * A_P);
    advance(b_mode, b_o, start_b, end_b, B_NP * B_P);
  endtask

  task automatic run_to_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (a_mode == 0 && b_mode == 0 && !go_a && !go_b) break;
      step();
    end
  endtask

  initial begin
    exp_t e0;
    reset = 0; start_a = 0; end_a = 0; start_b = 0; end_b = 0;
`ifdef FC_CU_RELU_EN
    relu_bypass = 0;
`endif
    repeat (3) step();
    reset = 1;
    repeat ($urandom_range(2, 6)) step();

    // Run 1: both instances, random spurious handshake pulses.
    go_a = 1; go_b = 1;
    run_to_idle(3000);
    chk("a.wr_count", wr_cnt_a, A_NP);
    chk("a.start_to_next_latency", stn_cyc_a - run_cyc_a, 738);
    chk("a.wm_addr_max", wm_max_a, 719);
    chk("b.wr_count", wr_cnt_b, 1);
    chk("b.start_to_next_latency", stn_cyc_b - run_cyc_b, B_NP * B_P);
    repeat ($urandom_range(1, 4)) step();

    // Run 2: reset in pass 2 at ifm_addr 50.
    go_a = 1;
    for (int k = 0; k < 1000; k++) begin
      if (a_mode == 1 && a_o == 2 * A_P + 50) break;
      step();
    end
    @(posedge clk);
    #1;
    chk("a.pre_reset_ifm_addr", 32'(a_ifa), 50);
    reset = 0;
    #1;
    a_mode = 0; b_mode = 0;
    e0 = model(0, 0, A_D, A_L, A_NP, A_NN, A_LN);
    check_all("a_rst", e0, a_etp, a_stn, a_rd, a_wrd, a_clr, a_mac, a_wr, a_busy,
              32'(a_ifa), 32'(a_wma), 32'(a_grp), 32'(a_mask));
    chk("a_rst.wm_addr", 32'(a_wma), 0);
    chk("a_rst.lane_mask", 32'(a_mask), 0);
    post_rst_wr = 0;
    repeat (3) step();
    reset = 1;
    repeat (300) step();
    chk("post_reset_no_write", post_rst_wr, 0);

    // Run 3: fresh start after reset.
    go_a = 1; go_b = 1;
    run_to_idle(3000);
    chk("a.wr_count_restart", wr_cnt_a, A_NP);
    chk("a.wm_addr_max_restart", wm_max_a, 719);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
